regfile_wb_arbiter: RTL and testbench

Shares the single write port of the integer register file among several writeback requesters, such as the ALU, the load unit and the CSR unit. Requesters are served round-robin over a valid/ready handshake. Each accepted write is registered for one cycle before it reaches the register file. While a write is staged, two forwarding lookups return the pending value for matching source registers. The block sits between the execute/writeback units and the register file write port.

---
 rtl/regfile_wb_arbiter_if.sv | 42 ++++
 rtl/regfile_wb_arbiter.sv | 87 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle, register-file write port and forwarding lookups
// shared between the writeback arbiter and its neighbours.
interface regfile_wb_arbiter_if #(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
  parameter int NUM_REQ           = 3
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ*REG_FILE_ADDR_LEN-1:0] req_addr;
  logic [NUM_REQ*XLEN-1:0]              req_data;

  logic                         wr_en;
  logic [REG_FILE_ADDR_LEN-1:0] wr_addr;
  logic [XLEN-1:0]              wr_data;

  logic [REG_FILE_ADDR_LEN-1:0] rs1;
  logic [REG_FILE_ADDR_LEN-1:0] rs2;
  logic                         fwd_1_valid;
  logic                         fwd_2_valid;
  logic [XLEN-1:0]              fwd_1_data;
  logic [XLEN-1:0]              fwd_2_data;

  logic [ID_W-1:0]              grant_id;

  // Execute/writeback side plus register-file read side.
  modport master (
    output req_valid, req_addr, req_data, rs1, rs2,
    input  req_ready, wr_en, wr_addr, wr_data,
    input  fwd_1_valid, fwd_2_valid, fwd_1_data, fwd_2_data, grant_id
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_addr, req_data, rs1, rs2,
    output req_ready, wr_en, wr_addr, wr_data,
    output fwd_1_valid, fwd_2_valid, fwd_1_data, fwd_2_data, grant_id
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a one-cycle
// write stage that also feeds two forwarding lookups.
module regfile_wb_arbiter #(
  parameter int XLEN              = 32,
  parameter int REG_FILE_DEPTH    = 32,
  parameter int REG_FILE_ADDR_LEN = $clog2(REG_FILE_DEPTH),
  parameter int NUM_REQ           = 3
) (
  input  logic                clk,
  input  logic                reset,
  regfile_wb_arbiter_if.slave bus
);
  localparam int AW   = REG_FILE_ADDR_LEN;
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] rr_ptr;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [XLEN-1:0] wr_data_q;
  logic [ID_W-1:0] grant_id_q;

  // Circular search starting at rr_ptr; the first valid requester wins.
  always_comb begin : grant_search
    int idx;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && bus.req_valid[ID_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // Ready is a pure function of valid and the pointer, never of ready itself.
  always_comb begin : ready_decode
    bus.req_ready = '0;
    if (grant_found) bus.req_ready[grant_idx] = 1'b1;
  end

  always_comb begin : grant_mux
    sel_addr = bus.req_addr[int'(grant_idx)*AW +: AW];
    sel_data = bus.req_data[int'(grant_idx)*XLEN +: XLEN];
  end

  // NOTE: state registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      grant_id_q <= '0;
      rr_ptr     <= '0;
    end else if (grant_found) begin
      // x0 writes complete the handshake and move the pointer but never commit.
      wr_en_q    <= (sel_addr != '0);
      wr_addr_q  <= sel_addr;
      wr_data_q  <= sel_data;
      grant_id_q <= grant_idx;
      rr_ptr     <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.grant_id = grant_id_q;

  // The staged write is the only value newer than the register file contents.
  assign bus.fwd_1_valid = wr_en_q && (wr_addr_q == bus.rs1) && (bus.rs1 != '0);
  assign bus.fwd_2_valid = wr_en_q && (wr_addr_q == bus.rs2) && (bus.rs2 != '0);
  assign bus.fwd_1_data  = bus.fwd_1_valid ? wr_data_q : '0;
  assign bus.fwd_2_data  = bus.fwd_2_valid ? wr_data_q : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset/ordering/round-robin
// sequences, and randomized traffic against a queue-free behavioural model.
module tb_regfile_wb_arbiter;
  localparam int XLEN    = 32;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int NUM_REQ = 3;

  logic clk = 1'b0;
  logic reset;

  regfile_wb_arbiter_if #(.XLEN(XLEN), .REG_FILE_DEPTH(DEPTH), .REG_FILE_ADDR_LEN(AW),
                          .NUM_REQ(NUM_REQ)) bus ();

  regfile_wb_arbiter #(.XLEN(XLEN), .REG_FILE_DEPTH(DEPTH), .REG_FILE_ADDR_LEN(AW),
                       .NUM_REQ(NUM_REQ)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: pointer, staged write, and the committed register file.
  int              m_ptr;
  bit              m_en;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  int              m_gid;
  logic [XLEN-1:0] m_rf [DEPTH];
  logic [XLEN-1:0] d_rf [DEPTH];
  int              last_g;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [4:0]  rs1, rs2;
    logic [2:0]  exp_ready;
    logic        exp_en;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_gid;
    logic        exp_f1, exp_f2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int model_grant(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic model_init();
    m_ptr = 0; m_en = 0; m_addr = '0; m_data = '0; m_gid = 0; last_g = -1;
    for (int i = 0; i < DEPTH; i++) begin
      m_rf[i] = '0;
      d_rf[i] = '0;
    end
  endtask

  task automatic clear_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
  endtask

  // Ends one time unit after a rising edge with reset released.
  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_init();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    bus.req_addr[i*AW +: AW]     = a;
    bus.req_data[i*XLEN +: XLEN] = d;
  endtask

  // One model-checked clock cycle; inputs must already be applied.
  task automatic cycle(input string tag);
    int              g;
    logic [NUM_REQ-1:0] exp_rdy;
    logic            f1, f2;
    logic [AW-1:0]   ga;
    logic [XLEN-1:0] gd;
    logic            stg_en;
    logic [AW-1:0]   stg_addr;
    logic [XLEN-1:0] stg_data;
    #2;
    g = model_grant(bus.req_valid, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check({tag, "_ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    f1 = m_en && (m_addr == bus.rs1) && (bus.rs1 != '0);
    f2 = m_en && (m_addr == bus.rs2) && (bus.rs2 != '0);
    check({tag, "_fwd1v"}, 64'(bus.fwd_1_valid), 64'(f1));
    check({tag, "_fwd1d"}, 64'(bus.fwd_1_data), f1 ? 64'(m_data) : 64'd0);
    check({tag, "_fwd2v"}, 64'(bus.fwd_2_valid), 64'(f2));
    check({tag, "_fwd2d"}, 64'(bus.fwd_2_data), f2 ? 64'(m_data) : 64'd0);
    ga = '0; gd = '0;
    if (g >= 0) begin
      ga = bus.req_addr[g*AW +: AW];
      gd = bus.req_data[g*XLEN +: XLEN];
    end
    stg_en = bus.wr_en; stg_addr = bus.wr_addr; stg_data = bus.wr_data;
    @(posedge clk);
    #1;
    if (stg_en) d_rf[stg_addr] = stg_data;
    if (m_en) m_rf[m_addr] = m_data;
    if (g >= 0) begin
      m_en = (ga != '0); m_addr = ga; m_data = gd; m_gid = g;
      m_ptr = (g + 1) % NUM_REQ;
    end else begin
      m_en = 0;
    end
    last_g = g;
    check({tag, "_wr_en"}, 64'(bus.wr_en), 64'(m_en));
    check({tag, "_wr_addr"}, 64'(bus.wr_addr), 64'(m_addr));
    check({tag, "_wr_data"}, 64'(bus.wr_data), 64'(m_data));
    check({tag, "_grant_id"}, 64'(bus.grant_id), 64'(m_gid));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_seq_a [6];
    int exp_seq_b [6];
    bit              pending [NUM_REQ];
    int              wait_cnt [NUM_REQ];
    int              rf_diff;

    vecs[0] = '{3'b001, 5'd7,  5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                5'd7, 5'd3, 3'b001, 1'b1, 5'd7, 32'hDEADBEEF, 2'd0, 1'b1, 1'b0};
    vecs[1] = '{3'b000, 5'd7,  5'd0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0,
                5'd7, 5'd3, 3'b000, 1'b0, 5'd7, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0};
    vecs[2] = '{3'b111, 5'd1,  5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                5'd2, 5'd2, 3'b010, 1'b1, 5'd2, 32'h22, 2'd1, 1'b1, 1'b1};
    vecs[3] = '{3'b111, 5'd1,  5'd2, 5'd3, 32'h11, 32'h22, 32'h33,
                5'd3, 5'd0, 3'b100, 1'b1, 5'd3, 32'h33, 2'd2, 1'b1, 1'b0};
    vecs[4] = '{3'b001, 5'd12, 5'd2, 5'd3, 32'h77, 32'h22, 32'h33,
                5'd12, 5'd0, 3'b001, 1'b1, 5'd12, 32'h77, 2'd0, 1'b1, 1'b0};
    vecs[5] = '{3'b100, 5'd12, 5'd2, 5'd0, 32'h77, 32'h22, 32'h1234,
                5'd0, 5'd0, 3'b100, 1'b0, 5'd0, 32'h1234, 2'd2, 1'b0, 1'b0};
    vecs[6] = '{3'b011, 5'd9,  5'd9, 5'd0, 32'h5, 32'hA5A5A5A5, 32'h1234,
                5'd3, 5'd9, 3'b001, 1'b1, 5'd9, 32'h5, 2'd0, 1'b0, 1'b1};
    vecs[7] = '{3'b010, 5'd9,  5'd9, 5'd0, 32'h5, 32'hA5A5A5A5, 32'h1234,
                5'd9, 5'd9, 3'b010, 1'b1, 5'd9, 32'hA5A5A5A5, 2'd1, 1'b1, 1'b1};
    vecs[8] = '{3'b001, 5'd31, 5'd9, 5'd0, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h1234,
                5'd31, 5'd30, 3'b001, 1'b1, 5'd31, 32'hFFFFFFFF, 2'd0, 1'b1, 1'b0};
    exp_seq_a = '{0, 1, 2, 0, 1, 2};
    exp_seq_b = '{0, 1, 2, 0, 2, 0};

    // Reset values straight out of reset.
    do_reset();
    #1;
    check("reset_wr_en", 64'(bus.wr_en), 64'd0);
    check("reset_grant_id", 64'(bus.grant_id), 64'd0);
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int v = 0; v < 9; v++) begin
      bus.req_valid = vecs[v].valid;
      bus.req_addr  = {vecs[v].a2, vecs[v].a1, vecs[v].a0};
      bus.req_data  = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
      bus.rs1       = vecs[v].rs1;
      bus.rs2       = vecs[v].rs2;
      #2;
      check($sformatf("vec%0d_ready", v), 64'(bus.req_ready), 64'(vecs[v].exp_ready));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_wr_en", v), 64'(bus.wr_en), 64'(vecs[v].exp_en));
      check($sformatf("vec%0d_wr_addr", v), 64'(bus.wr_addr), 64'(vecs[v].exp_addr));
      check($sformatf("vec%0d_wr_data", v), 64'(bus.wr_data), 64'(vecs[v].exp_data));
      check($sformatf("vec%0d_grant_id", v), 64'(bus.grant_id), 64'(vecs[v].exp_gid));
      check($sformatf("vec%0d_fwd1v", v), 64'(bus.fwd_1_valid), 64'(vecs[v].exp_f1));
      check($sformatf("vec%0d_fwd1d", v), 64'(bus.fwd_1_data),
            vecs[v].exp_f1 ? 64'(vecs[v].exp_data) : 64'd0);
      check($sformatf("vec%0d_fwd2v", v), 64'(bus.fwd_2_valid), 64'(vecs[v].exp_f2));
      check($sformatf("vec%0d_fwd2d", v), 64'(bus.fwd_2_data),
            vecs[v].exp_f2 ? 64'(vecs[v].exp_data) : 64'd0);
    end

    // Reset asserted mid-stream drops the staged write immediately.
    do_reset();
    bus.req_valid = 3'b010;
    set_req(1, 5'd5, 32'hCAFEF00D);
    cycle("rst_pre");
    #2 reset = 1'b0;
    #1;
    check("rst_async_wr_en", 64'(bus.wr_en), 64'd0);
    check("rst_async_wr_addr", 64'(bus.wr_addr), 64'd0);
    check("rst_async_wr_data", 64'(bus.wr_data), 64'd0);
    check("rst_async_grant_id", 64'(bus.grant_id), 64'd0);
    check("rst_async_ready", 64'(bus.req_ready), 64'b010);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_init();
    cycle("rst_post");
    check("rst_post_gid", 64'(bus.grant_id), 64'd1);

    // Round-robin with all three continuously valid.
    do_reset();
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    for (int c = 0; c < 6; c++) begin
      cycle($sformatf("rr_a%0d", c));
      check($sformatf("rr_a%0d_seq", c), 64'(bus.grant_id), 64'(exp_seq_a[c]));
    end

    // Round-robin with requester 1 dropping after its first grant.
    do_reset();
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'hB0); set_req(1, 5'd2, 32'hB1); set_req(2, 5'd3, 32'hB2);
    for (int c = 0; c < 6; c++) begin
      if (c == 2) bus.req_valid = 3'b101;
      cycle($sformatf("rr_b%0d", c));
      check($sformatf("rr_b%0d_seq", c), 64'(bus.grant_id), 64'(exp_seq_b[c]));
    end

    // Same destination from two requesters: grant order is write order.
    do_reset();
    bus.req_valid = 3'b011;
    set_req(0, 5'd4, 32'd1); set_req(1, 5'd4, 32'd2);
    cycle("same0");
    check("same0_data", 64'(bus.wr_data), 64'd1);
    bus.req_valid = 3'b010;
    cycle("same1");
    check("same1_data", 64'(bus.wr_data), 64'd2);
    bus.req_valid = 3'b000;
    cycle("same2");
    check("same_final_r4", 64'(d_rf[4]), 64'd2);

    // Randomized traffic honouring hold-until-handshake.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      pending[i] = 0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pending[i] && ($urandom % 3 != 0)) begin
          pending[i] = 1;
          wait_cnt[i] = 1;
          set_req(i, ($urandom % 8 == 0) ? 5'd0 : AW'($urandom), $urandom);
        end
        bus.req_valid[i] = pending[i];
      end
      bus.rs1 = ($urandom % 2 == 0) ? m_addr : AW'($urandom);
      bus.rs2 = ($urandom % 2 == 0) ? m_addr : AW'($urandom);
      cycle("rnd");
      if (last_g >= 0) begin
        check("rnd_fairness", 64'(wait_cnt[last_g] <= NUM_REQ), 64'd1);
        pending[last_g] = 0;
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (pending[i]) wait_cnt[i]++;
    end
    clear_inputs();
    cycle("rnd_flush");
    rf_diff = 0;
    for (int r = 0; r < DEPTH; r++)
      if (d_rf[r] !== m_rf[r]) rf_diff++;
    check("rnd_regfile_contents", 64'(rf_diff), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
